// File: rtl/knn_top4_merger_if.sv
// ============================================================================
// Module      : knn_top4_merger_if
// Description : Batch-input / result-output bundle for the k-NN top-4 merger.
//               The master side feeds sorted candidate batches and consumes
//               the final result; the slave side is the merger itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface knn_top4_merger_if #(
    parameter int DATA_W = 25,
    parameter int IDX_W  = 15
);
    // Batch input
    logic              valid_in;
    logic              last_in;
    logic [DATA_W-1:0] data_in_0;
    logic [DATA_W-1:0] data_in_1;
    logic [DATA_W-1:0] data_in_2;
    logic [DATA_W-1:0] data_in_3;
    logic [IDX_W-1:0]  idx_in_0;
    logic [IDX_W-1:0]  idx_in_1;
    logic [IDX_W-1:0]  idx_in_2;
    logic [IDX_W-1:0]  idx_in_3;
    logic              in_ready;

    // Result output
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out_0;
    logic [DATA_W-1:0] data_out_1;
    logic [DATA_W-1:0] data_out_2;
    logic [DATA_W-1:0] data_out_3;
    logic [IDX_W-1:0]  idx_out_0;
    logic [IDX_W-1:0]  idx_out_1;
    logic [IDX_W-1:0]  idx_out_2;
    logic [IDX_W-1:0]  idx_out_3;
    logic [7:0]        batch_cnt;

    modport master (
        output valid_in, last_in,
        output data_in_0, data_in_1, data_in_2, data_in_3,
        output idx_in_0, idx_in_1, idx_in_2, idx_in_3,
        output out_ready,
        input  in_ready, out_valid,
        input  data_out_0, data_out_1, data_out_2, data_out_3,
        input  idx_out_0, idx_out_1, idx_out_2, idx_out_3,
        input  batch_cnt
    );

    modport slave (
        input  valid_in, last_in,
        input  data_in_0, data_in_1, data_in_2, data_in_3,
        input  idx_in_0, idx_in_1, idx_in_2, idx_in_3,
        input  out_ready,
        output in_ready, out_valid,
        output data_out_0, data_out_1, data_out_2, data_out_3,
        output idx_out_0, idx_out_1, idx_out_2, idx_out_3,
        output batch_cnt
    );
endinterface

`default_nettype wire

// File: rtl/knn_top4_merger.sv
// ============================================================================
// Module      : knn_top4_merger
// Description : Keeps a running ascending list of the 4 smallest distances
//               across all batches of a query, merging one sorted 4-batch per
//               cycle through a bitonic min + half-cleaner network, and hands
//               the final list to the consumer with a valid/ready hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module knn_top4_merger #(
    parameter int DATA_W = 25,
    parameter int IDX_W  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    knn_top4_merger_if.slave    bus
);

    localparam logic [DATA_W-1:0] C_EMPTY_D = '1;
    localparam logic [IDX_W-1:0]  C_EMPTY_I = '0;
    localparam logic [7:0]        C_CNT_MAX = 8'hFF;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;

    logic [DATA_W-1:0] r_dist [4];
    logic [IDX_W-1:0]  r_idx  [4];
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_inc;

    logic [DATA_W-1:0] r_out_d [4];
    logic [IDX_W-1:0]  r_out_i [4];
    logic [7:0]        r_out_cnt;

    logic [DATA_W-1:0] w_in_d [4];
    logic [IDX_W-1:0]  w_in_i [4];

    // Tags record where each element came from: {from_batch, position}.
    // Running-list elements (tag 0xx) outrank batch elements (tag 1xx) and
    // lower positions outrank higher ones, so on equal distances the
    // earlier-arrived candidate always lands first and the network is stable.
    logic [DATA_W-1:0] w_s1_d [4];
    logic [IDX_W-1:0]  w_s1_i [4];
    logic [2:0]        w_s1_t [4];
    logic [DATA_W-1:0] w_s2_d [4];
    logic [IDX_W-1:0]  w_s2_i [4];
    logic [2:0]        w_s2_t [4];
    logic [DATA_W-1:0] w_m_d  [4];
    logic [IDX_W-1:0]  w_m_i  [4];

    assign w_in_d[0] = bus.data_in_0;
    assign w_in_d[1] = bus.data_in_1;
    assign w_in_d[2] = bus.data_in_2;
    assign w_in_d[3] = bus.data_in_3;
    assign w_in_i[0] = bus.idx_in_0;
    assign w_in_i[1] = bus.idx_in_1;
    assign w_in_i[2] = bus.idx_in_2;
    assign w_in_i[3] = bus.idx_in_3;

    // Step 1: element-wise min of the list against the reversed batch gives
    // a bitonic sequence holding the 4 smallest of the 8 candidates.
    for (genvar gi = 0; gi < 4; gi++) begin : g_step1
        localparam int J = 3 - gi;
        logic w_take_in;
        assign w_take_in  = w_in_d[J] < r_dist[gi];
        assign w_s1_d[gi] = w_take_in ? w_in_d[J] : r_dist[gi];
        assign w_s1_i[gi] = w_take_in ? w_in_i[J] : r_idx[gi];
        assign w_s1_t[gi] = w_take_in ? {1'b1, 2'(J)} : {1'b0, 2'(gi)};
    end

    // Step 2: half-cleaner on pairs (0,2) and (1,3).
    for (genvar gp = 0; gp < 2; gp++) begin : g_hc_far
        localparam int LO = gp;
        localparam int HI = gp + 2;
        logic w_swap;
        assign w_swap = (w_s1_d[HI] < w_s1_d[LO]) ||
                        ((w_s1_d[HI] == w_s1_d[LO]) && (w_s1_t[HI] < w_s1_t[LO]));
        assign w_s2_d[LO] = w_swap ? w_s1_d[HI] : w_s1_d[LO];
        assign w_s2_i[LO] = w_swap ? w_s1_i[HI] : w_s1_i[LO];
        assign w_s2_t[LO] = w_swap ? w_s1_t[HI] : w_s1_t[LO];
        assign w_s2_d[HI] = w_swap ? w_s1_d[LO] : w_s1_d[HI];
        assign w_s2_i[HI] = w_swap ? w_s1_i[LO] : w_s1_i[HI];
        assign w_s2_t[HI] = w_swap ? w_s1_t[LO] : w_s1_t[HI];
    end

    // Step 3: half-cleaner on pairs (0,1) and (2,3) finishes the ascending sort.
    for (genvar gp = 0; gp < 2; gp++) begin : g_hc_near
        localparam int LO = 2 * gp;
        localparam int HI = 2 * gp + 1;
        logic w_swap;
        assign w_swap = (w_s2_d[HI] < w_s2_d[LO]) ||
                        ((w_s2_d[HI] == w_s2_d[LO]) && (w_s2_t[HI] < w_s2_t[LO]));
        assign w_m_d[LO] = w_swap ? w_s2_d[HI] : w_s2_d[LO];
        assign w_m_i[LO] = w_swap ? w_s2_i[HI] : w_s2_i[LO];
        assign w_m_d[HI] = w_swap ? w_s2_d[LO] : w_s2_d[HI];
        assign w_m_i[HI] = w_swap ? w_s2_i[LO] : w_s2_i[HI];
    end

    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? C_CNT_MAX : r_cnt + 8'd1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ACCUM;
        else        r_state <= w_state_nxt;
    end

    // Next state and handshake decode (handshakes depend on state only).
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                w_in_ready = 1'b1;
                if (bus.valid_in && bus.last_in) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = ST_ACCUM;
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    assign w_accept = bus.valid_in && w_in_ready;

    // Running list, batch counter and delivered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_dist[k]  <= C_EMPTY_D;
                r_idx[k]   <= C_EMPTY_I;
                r_out_d[k] <= '0;
                r_out_i[k] <= '0;
            end
            r_cnt     <= 8'd0;
            r_out_cnt <= 8'd0;
        end else if (w_accept) begin
            if (bus.last_in) begin
                for (int k = 0; k < 4; k++) begin
                    r_out_d[k] <= w_m_d[k];
                    r_out_i[k] <= w_m_i[k];
                    r_dist[k]  <= C_EMPTY_D;
                    r_idx[k]   <= C_EMPTY_I;
                end
                r_out_cnt <= w_cnt_inc;
                r_cnt     <= 8'd0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    r_dist[k] <= w_m_d[k];
                    r_idx[k]  <= w_m_i[k];
                end
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.data_out_0 = r_out_d[0];
    assign bus.data_out_1 = r_out_d[1];
    assign bus.data_out_2 = r_out_d[2];
    assign bus.data_out_3 = r_out_d[3];
    assign bus.idx_out_0  = r_out_i[0];
    assign bus.idx_out_1  = r_out_i[1];
    assign bus.idx_out_2  = r_out_i[2];
    assign bus.idx_out_3  = r_out_i[3];
    assign bus.batch_cnt  = r_out_cnt;

endmodule

`default_nettype wire

// File: tb/tb_knn_top4_merger.sv
// ============================================================================
// Module      : tb_knn_top4_merger
// Description : Directed self-checking bench for knn_top4_merger with
//               hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_knn_top4_merger;

    localparam int DATA_W = 25;
    localparam int IDX_W  = 15;
    localparam logic [DATA_W-1:0] C_E = '1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    knn_top4_merger_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    knn_top4_merger #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic set_batch(input logic [DATA_W-1:0] d0, d1, d2, d3,
                             input logic [IDX_W-1:0] i0, i1, i2, i3,
                             input logic last);
        bus.valid_in  = 1'b1;
        bus.last_in   = last;
        bus.data_in_0 = d0; bus.data_in_1 = d1; bus.data_in_2 = d2; bus.data_in_3 = d3;
        bus.idx_in_0  = i0; bus.idx_in_1  = i1; bus.idx_in_2  = i2; bus.idx_in_3  = i3;
    endtask

    // Present a batch for one clock edge (accepted when in ACCUM).
    task automatic send(input logic [DATA_W-1:0] d0, d1, d2, d3,
                        input logic [IDX_W-1:0] i0, i1, i2, i3,
                        input logic last);
        set_batch(d0, d1, d2, d3, i0, i1, i2, i3, last);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
    endtask

    task automatic check_result(input string tag,
                                input logic [DATA_W-1:0] d0, d1, d2, d3,
                                input logic [IDX_W-1:0] i0, i1, i2, i3,
                                input logic [7:0] cnt);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'd0);
        chk({tag, ".d0"}, 32'(bus.data_out_0), 32'(d0));
        chk({tag, ".d1"}, 32'(bus.data_out_1), 32'(d1));
        chk({tag, ".d2"}, 32'(bus.data_out_2), 32'(d2));
        chk({tag, ".d3"}, 32'(bus.data_out_3), 32'(d3));
        chk({tag, ".i0"}, 32'(bus.idx_out_0), 32'(i0));
        chk({tag, ".i1"}, 32'(bus.idx_out_1), 32'(i1));
        chk({tag, ".i2"}, 32'(bus.idx_out_2), 32'(i2));
        chk({tag, ".i3"}, 32'(bus.idx_out_3), 32'(i3));
        chk({tag, ".cnt"}, 32'(bus.batch_cnt), 32'(cnt));
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, ".rel_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".rel_ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        set_batch('0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        bus.valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready",  32'(bus.in_ready),   32'd1);
        chk("rst.out_valid", 32'(bus.out_valid),  32'd0);
        chk("rst.d0",        32'(bus.data_out_0), 32'd0);
        chk("rst.d3",        32'(bus.data_out_3), 32'd0);
        chk("rst.i0",        32'(bus.idx_out_0),  32'd0);
        chk("rst.cnt",       32'(bus.batch_cnt),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single batch, last
        send(5, 9, 12, 20, 1, 2, 3, 4, 1'b1);
        check_result("single", 5, 9, 12, 20, 1, 2, 3, 4, 8'd1);
        release_result("single");

        // Two back-to-back batches
        set_batch(10, 20, 30, 40, 0, 1, 2, 3, 1'b0);
        @(posedge clk); #1;
        send(15, 25, 35, 45, 10, 11, 12, 13, 1'b1);
        check_result("b2b", 10, 15, 20, 25, 0, 10, 1, 11, 8'd2);
        release_result("b2b");

        // Equal distances keep arrival order
        send(7, 7, 50, 60, 1, 2, 3, 4, 1'b0);
        send(7, 8, 9, 10, 5, 6, 7, 8, 1'b1);
        check_result("tie", 7, 7, 7, 8, 1, 2, 5, 6, 8'd2);
        release_result("tie");

        // Fewer than 4 real candidates
        send(4, C_E, C_E, C_E, 9, 0, 0, 0, 1'b1);
        check_result("sparse", 4, C_E, C_E, C_E, 9, 0, 0, 0, 8'd1);
        release_result("sparse");

        // Backpressure: valid_in held high while the result is held
        send(3, 4, 5, 6, 20, 21, 22, 23, 1'b1);
        set_batch(1, 2, 2, 2, 30, 31, 32, 33, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp.out_valid", 32'(bus.out_valid),  32'd1);
            chk("bp.in_ready",  32'(bus.in_ready),   32'd0);
            chk("bp.d0",        32'(bus.data_out_0), 32'd3);
            chk("bp.i3",        32'(bus.idx_out_3),  32'd23);
            chk("bp.cnt",       32'(bus.batch_cnt),  32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp.acc_valid", 32'(bus.out_valid),  32'd0);
        chk("bp.acc_ready", 32'(bus.in_ready),   32'd1);
        chk("bp.keep_d0",   32'(bus.data_out_0), 32'd3);
        chk("bp.keep_cnt",  32'(bus.batch_cnt),  32'd1);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
        check_result("bp.next", 1, 2, 2, 2, 30, 31, 32, 33, 8'd1);
        release_result("bp.next");

        // Reset mid-query discards the partial list
        send(1, 2, 3, 4, 1, 2, 3, 4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.in_ready",  32'(bus.in_ready),   32'd1);
        chk("midrst.out_valid", 32'(bus.out_valid),  32'd0);
        chk("midrst.d0",        32'(bus.data_out_0), 32'd0);
        chk("midrst.cnt",       32'(bus.batch_cnt),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(50, 60, 70, 80, 5, 6, 7, 8, 1'b1);
        check_result("midrst", 50, 60, 70, 80, 5, 6, 7, 8, 8'd1);
        release_result("midrst");

        // 300 back-to-back batches: counter saturates at 255
        for (int k = 0; k < 300; k++) begin
            set_batch(DATA_W'(5000 - 2 * k), DATA_W'(5001 - 2 * k),
                      DATA_W'(5004 - 2 * k), DATA_W'(5005 - 2 * k),
                      IDX_W'(4 * k), IDX_W'(4 * k + 1), IDX_W'(4 * k + 2), IDX_W'(4 * k + 3),
                      (k == 299));
            @(posedge clk); #1;
        end
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
        check_result("sat", 4402, 4403, 4404, 4405, 1196, 1197, 1192, 1193, 8'd255);
        release_result("sat");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/knn_top4_merger.md
KNN_TOP4_MERGER -- requirements
Module: knn_top4_merger

Interface
REQ-001 Parameter DATA_W, default 25: distance width, equal to the upstream sorter's data width.
REQ-002 Parameter IDX_W, default 15: candidate index width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 valid_in  input  1  batch of 4 sorted candidates present; from sorter valid_out.
REQ-006 data_in_0..data_in_3  input  DATA_W each  batch distances, ascending (data_in_0 smallest).
REQ-007 idx_in_0..idx_in_3  input  IDX_W each  indices paired with data_in_n.
REQ-008 last_in  input  1  qualifies valid_in; batch is the final one for the current query.
REQ-009 in_ready  output  1  block accepts a batch this cycle.
REQ-010 out_valid  output  1  final top-4 result held on outputs.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 data_out_0..data_out_3  output  DATA_W each  final 4 smallest distances, ascending.
REQ-013 idx_out_0..idx_out_3  output  IDX_W each  indices paired with data_out_n.
REQ-014 batch_cnt  output  8  batches merged into the delivered result, saturating at 255.

Function
REQ-015 Running list: 4 (distance, index) register pairs R0..R3, always ascending; empty slot = distance all-ones, index 0.
REQ-016 Batch accepted iff valid_in && in_ready at a rising edge; otherwise inputs ignored.
REQ-017 Merge on accept: step 1 M_i = min(R_i, in_(3-i)), i=0..3 (bitonic sequence); steps 2-3: two half-cleaner levels (pairs 0/2, 1/3, then 0/1, 2/3) producing ascending 4; all combinational, result registered same edge.
REQ-018 Tie rule: every compare selects the running-list element, or the lower-position element, when distances are equal, so earlier-arrived candidates rank first.
REQ-019 Throughput: one batch per cycle in ACCUM; back-to-back valid_in with no bubbles SHALL merge correctly.
REQ-020 States: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1); in_ready and out_valid decoded from state only.
REQ-021 ACCUM, accept with last_in=0: R <= merged result; internal counter += 1 (saturating 255); stay ACCUM.
REQ-022 ACCUM, accept with last_in=1: data_out/idx_out <= merged result; batch_cnt <= counter+1 (saturating); R <= empty; counter <= 0; go HOLD.
REQ-023 Latency: last batch accepted at edge N -> out_valid high and outputs valid from edge N to the edge where out_ready is sampled high.
REQ-024 HOLD: outputs and batch_cnt stable while out_ready=0; on out_ready=1 go ACCUM at that edge; valid_in in HOLD is ignored (in_ready=0), including in the cycle out_ready is high.
REQ-025 Outputs hold their last delivered values after returning to ACCUM until the next result.
REQ-026 Query with fewer than 4 real candidates delivers empty-slot values (all-ones, index 0) in the unused high positions.

Reset
REQ-027 rst_n low SHALL immediately force: state ACCUM, in_ready=1, out_valid=0, data_out_*=0, idx_out_*=0, batch_cnt=0, R all empty, counter 0.
REQ-028 Reset asserted mid-query or in HOLD discards the partial list and pending result; first accept after release starts a new query.

Verification
REQ-029 Single batch: data (5,9,12,20) idx (1,2,3,4), last_in=1 -> next cycle out_valid=1, data_out (5,9,12,20), idx (1,2,3,4), batch_cnt=1.
REQ-030 Two back-to-back batches: (10,20,30,40)/idx(0..3), then (15,25,35,45)/idx(10..13) last -> data_out (10,15,20,25), idx (0,10,1,11), batch_cnt=2.
REQ-031 Tie: batch (7,7,50,60)/idx(1,2,3,4) then (7,8,9,10)/idx(5,6,7,8) last -> data_out (7,7,7,8), idx (1,2,5,6).
REQ-032 Backpressure: out_ready=0 for 5 cycles with valid_in held high -> outputs constant, in_ready=0, no batch consumed; out_ready=1 -> ACCUM next edge, next batch accepted after.
REQ-033 Reset mid-query: merge (1,2,3,4), assert rst_n low, release, send (50,60,70,80) last -> data_out (50,60,70,80), batch_cnt=1.
REQ-034 Saturation: 300 batches, last flagged -> batch_cnt=255, data_out equals the 4 smallest distances sent.
